// File: rtl/rad4_booth_mul_pipe_v2.sv
// Pipelined radix-4 Booth multiplier, any operand widths, run-time sign modes.
// Stages: operand regs, Booth rows, registered binary adder tree.
module rad4_booth_mul_pipe_v2 #(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 en_i,
  input  logic                                 valid_i,
  input  logic                                 sgn1_i,
  input  logic                                 sgn2_i,
  input  logic [DATA_WIDTH_1-1:0]              x1_i,
  input  logic [DATA_WIDTH_2-1:0]              x2_i,
  output logic                                 valid_o,
  output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] y_o
);

  localparam int W1  = DATA_WIDTH_1;
  localparam int W2  = DATA_WIDTH_2;
  localparam int PW  = W1 + W2;
  localparam int NPP = (W1 + 2) / 2;
  localparam int E1  = 2 * NPP;
  localparam int LVL = $clog2(NPP);
  localparam int LAT = 2 + LVL;

  function automatic int lvl_n(input int l);
    return (NPP + (1 << l) - 1) >> l;
  endfunction

  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int j = 0; j < l; j++) o += lvl_n(j);
    return o;
  endfunction

  localparam int TOT = lvl_off(LVL) + 1;

  logic [W1-1:0]  x1_q;
  logic [W2-1:0]  x2_q;
  logic           s1_q;
  logic           s2_q;
  logic [LAT-1:0] v_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x1_q <= '0;
      x2_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      v_q  <= '0;
    end else if (en_i) begin
      x1_q <= x1_i;
      x2_q <= x2_i;
      s1_q <= sgn1_i;
      s2_q <= sgn2_i;
      v_q  <= {v_q[LAT-2:0], valid_i};
    end
  end

  // z carries the implicit zero below bit 0 of the extended multiplier
  logic [E1:0]    z;
  logic [PW-1:0]  x2e;
  logic [PW-1:0]  pp_d [NPP];
  logic [2:0]     trip;
  logic           one;
  logic           two;
  logic           neg;
  logic [PW-1:0]  row;

  assign z   = {{(E1-W1){s1_q & x1_q[W1-1]}}, x1_q, 1'b0};
  assign x2e = {{(PW-W2){s2_q & x2_q[W2-1]}}, x2_q};

  always_comb begin
    trip = '0;
    one  = 1'b0;
    two  = 1'b0;
    neg  = 1'b0;
    row  = '0;
    for (int k = 0; k < NPP; k++) begin
      trip = z[2*k +: 3];
      one  = trip[1] ^ trip[0];
      two  = (trip == 3'b011) || (trip == 3'b100);
      neg  = trip[2] & ~(trip[1] & trip[0]);
      unique case (1'b1)
        one:     row = x2e;
        two:     row = x2e << 1;
        default: row = '0;
      endcase
      row     = row << (2 * k);
      pp_d[k] = (neg ? ~row : row) + PW'(neg);
    end
  end

  // All tree levels live in one array, level l starting at lvl_off(l)
  logic [PW-1:0] nd_q [TOT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TOT; i++) nd_q[i] <= '0;
    end else if (en_i) begin
      for (int k = 0; k < NPP; k++) nd_q[k] <= pp_d[k];
      for (int l = 0; l < LVL; l++) begin
        for (int i = 0; i < (NPP + 1) / 2; i++) begin
          if (i < lvl_n(l + 1) && (l < LVL - 1 || v_q[LAT-2])) begin
            if (2 * i + 1 < lvl_n(l))
              nd_q[lvl_off(l+1)+i] <= nd_q[lvl_off(l)+2*i]
                                    + nd_q[lvl_off(l)+2*i+1];
            else
              nd_q[lvl_off(l+1)+i] <= nd_q[lvl_off(l)+2*i];
          end
        end
      end
    end
  end

  assign y_o     = nd_q[TOT-1];
  assign valid_o = v_q[LAT-1];

endmodule

// File: doc/rad4_booth_mul_pipe_v2.md
Name: rad4_booth_mul_pipe_v2

Overview:
Parametrised, fully pipelined radix-4 Booth multiplier. Supports arbitrary operand widths (odd or even) and per-operand signed/unsigned mode selected at run time. Returns the full-width product with a valid strobe and a global pipeline-enable stall. It is the successor to the fixed 8-bit Booth pipeline and feeds the MAC/filter datapaths at one product per cycle.

Parameters:
DATA_WIDTH_1, 8, multiplier (x1) width, >=2, odd allowed
DATA_WIDTH_2, 8, multiplicand (x2) width, >=2, odd allowed
NPP (localparam), ceil((DATA_WIDTH_1+1)/2), number of Booth partial products
LAT (localparam), 2+ceil(log2(NPP)), input-to-output latency in enabled cycles

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
en_i  in  1  pipeline enable; 0 freezes every register (stall)
valid_i  in  1  x1_i/x2_i/sgn qualifiers valid this cycle
sgn1_i  in  1  1 = x1_i is two's complement, 0 = unsigned
sgn2_i  in  1  1 = x2_i is two's complement, 0 = unsigned
x1_i  in  DATA_WIDTH_1  multiplier
x2_i  in  DATA_WIDTH_2  multiplicand
valid_o  out  1  y_o carries a new product
y_o  out  DATA_WIDTH_1+DATA_WIDTH_2  full product, two's complement if either operand is signed, else unsigned

Behaviour:
- Reset: async on resetn low; all pipeline registers, valid_o and y_o go to 0 immediately. Reset mid-operation discards all in-flight products; no valid_o until new valid_i is accepted after release.
- Stage 1: register x1_i, x2_i, sgn*_i, valid_i when en_i=1.
- Operand extension: x1 is extended by one bit (copy of MSB if sgn1, else 0) to DATA_WIDTH_1+1, then by one more identical bit if needed to reach an even width. x2 is extended to DATA_WIDTH_2+1 the same way using sgn2. Implicit z(-1)=0.
- Stage 2: NPP Booth digits in {-2,-1,0,+1,+2} are generated and registered. Partial product k is weighted 4^k. Negation is via invert plus carry-in, folded into the same row; no separate correction pass.
- Stages 3..LAT: binary adder tree, one registered level per ceil(log2(NPP)) level. An odd row count passes the leftover row through a register to the next level. Each level is sign-extended to cover the full product width.
- Output: y_o = low DATA_WIDTH_1+DATA_WIDTH_2 bits of the exact product. It is always exact: no overflow is possible for any sign combination.
- Valid: a 1-bit shift register of depth LAT, advancing only when en_i=1. valid_o is asserted exactly LAT enabled cycles after valid_i was sampled.
- y_o updates only when a valid result exits the tree and holds its value otherwise. Bubbles never disturb y_o.
- Stall: en_i=0 holds every stage including valid_o/y_o. Inputs presented during a stall are ignored.
- Throughput: one product per enabled cycle; back-to-back valid_i is accepted without gaps.
- Mode changes take effect per sample; sgn bits travel with their operands.
- Default 8x8: NPP=5, LAT=5.

Test Plan:
- 8x8, sgn1=sgn2=1, x1=0x80, x2=0x80 -> after 5 cycles valid_o=1, y_o=0x4000. Repeat with x1=0x7F, x2=0x80 -> y_o=0xC080.
- 8x8 unsigned, x1=0xFF, x2=0xFF -> y_o=0xFE01. Mixed sgn1=1, sgn2=0, x1=0xFF, x2=0xFF -> y_o=0xFF01 (-255).
- Stream 20 back-to-back random signed pairs -> 20 consecutive valid_o pulses starting at cycle 5, each matching the model in order. Then insert a valid_i=0 gap -> one valid_o gap, y_o held.
- Hold en_i=0 for 3 cycles with 3 products in flight -> outputs frozen. After release the products emerge in order with total latency 5+3 cycles.
- Pulse resetn low for 1 cycle with 4 products in flight -> y_o=0 and valid_o=0 immediately, and no stale valid_o afterwards.
- Parameters 7x5, exhaustive over all four sign modes (NPP=4, LAT=4) -> every product matches the reference model.
